// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } sram_state_t;

    localparam int          SRAM_ADDR_W       = 18;
    localparam int          SRAM_DATA_W       = 16;
    localparam int          WAIT_W            = 4;
    localparam int unsigned BASE_ADDR_DEFAULT = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: done is high while the count equals WAIT_CYCLES.
module sram_wait_counter
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic done
);

    localparam logic [WAIT_W-1:0] LP_WAIT = 4'(WAIT_CYCLES);

    logic [WAIT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (!done) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == LP_WAIT);

endmodule

// File: rtl/sram_controller.sv
// Moves one 32-bit word over a 16-bit SRAM bus as two halfword phases.
// Define SRAM_ALIGN_CHECK_EN to reject misaligned / below-base addresses with err.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic                   err,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam logic [31:0] LP_BASE = 32'(BASE_ADDR);

    sram_state_t              r_state;
    logic [31:0]              r_rdata;
    logic [SRAM_ADDR_W-1:0]   r_sram_addr;
    logic [SRAM_DATA_W-1:0]   r_dq_out;
    logic [SRAM_DATA_W-1:0]   r_wdata_hi;
    logic                     r_dq_oe;
    logic                     r_we_n;

    logic [31:0]              w_off;
    logic [SRAM_ADDR_W-2:0]   w_word;
    logic                     w_req;
    logic                     w_bad;
    logic                     w_done;
    logic                     w_clr;
    logic                     w_unused;

    assign w_off    = address - LP_BASE;
    assign w_word   = w_off[18:2];
    assign w_unused = ^{w_off[31:19], w_off[1:0]};
    assign w_req    = rd_en | wr_en;

`ifdef SRAM_ALIGN_CHECK_EN
    logic r_err;

    assign w_bad = w_req && ((address[1:0] != 2'b00) || (address < LP_BASE));

    // Every request accepted in IDLE refreshes the flag, so a legal one clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == ST_IDLE && w_req) begin
            r_err <= w_bad;
        end
    end

    assign err = r_err;
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    // Counter restarts on every state change; IDLE and DONE hold it cleared.
    assign w_clr = w_done || (r_state == ST_IDLE) || (r_state == ST_DONE);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .done (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rdata     <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_wdata_hi  <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_bad) begin
                        r_state <= ST_DONE;
                    end else if (wr_en) begin
                        r_state     <= ST_WR_LO;
                        r_sram_addr <= {w_word, 1'b0};
                        r_dq_out    <= wdata[15:0];
                        r_wdata_hi  <= wdata[31:16];
                        r_dq_oe     <= 1'b1;
                        r_we_n      <= 1'b0;
                    end else if (rd_en) begin
                        r_state     <= ST_RD_LO;
                        r_sram_addr <= {w_word, 1'b0};
                    end
                end
                ST_RD_LO: begin
                    if (w_done) begin
                        r_rdata[15:0] <= sram_dq_in;
                        r_sram_addr[0] <= 1'b1;
                        r_state       <= ST_RD_HI;
                    end
                end
                ST_RD_HI: begin
                    if (w_done) begin
                        r_rdata[31:16] <= sram_dq_in;
                        r_state        <= ST_DONE;
                    end
                end
                ST_WR_LO: begin
                    if (w_done) begin
                        r_sram_addr[0] <= 1'b1;
                        r_dq_out       <= r_wdata_hi;
                        r_state        <= ST_WR_HI;
                    end
                end
                ST_WR_HI: begin
                    if (w_done) begin
                        r_dq_oe <= 1'b0;
                        r_we_n  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready       = !w_req || (r_state == ST_DONE);
    assign rdata       = r_rdata;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_dq_out;
    assign sram_dq_oe  = r_dq_oe;
    assign sram_we_n   = r_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: stimulus queues expected completions,
// a negedge monitor checks rdata/err/latency whenever a request completes.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .err         (err),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n)
    );

    // Halfword SRAM model
    logic [15:0] mem [0:63];
    assign sram_dq_in = mem[sram_addr[5:0]];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) mem[sram_addr[5:0]] <= sram_dq_out;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          start;
        int          lat;
        string       name;
    } exp_t;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
    } wr_t;

    exp_t sb[$];
    wr_t  wlog[$];
    int   done_cyc[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    exp_t mon_e;
    wr_t  mon_w;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: logs write strobes and scores every completed request.
    always @(negedge clk) begin
        if (!rst && !sram_we_n) begin
            mon_w.a = sram_addr;
            mon_w.d = sram_dq_out;
            wlog.push_back(mon_w);
        end
        if (!rst && (rd_en || wr_en) && ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=done_at_%0d required=no_pending_request", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_rdata"}, rdata, mon_e.rdata);
                check({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
                check({mon_e.name, "_latency"}, 32'(cyc - mon_e.start), 32'(mon_e.lat));
                $display("txn %s rdata=%h err=%0b latency=%0d", mon_e.name, rdata, err,
                         cyc - mon_e.start);
            end
            done_cyc.push_back(cyc);
            done_cnt++;
        end
    end

    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err, input int lat, input string name);
        exp_t e;
        rd_en   = rd;
        wr_en   = wr;
        address = a;
        wdata   = wd;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.start = cyc;
        e.lat   = lat;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        int start_cnt;
        bit ok;
        start_cnt = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start_cnt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_ready required=ready_within_40", name);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [17:0] exp_a [4];
        logic [15:0] exp_d [4];

        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = 16'hA000 | 16'(i);
        mem[4] = 16'hBEEF;
        mem[5] = 16'hDEAD;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset_rdata", rdata, 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_we_n", 32'(sram_we_n), 32'h1);
        check("reset_oe", 32'(sram_dq_oe), 32'h0);
        check("reset_addr", 32'(sram_addr), 32'h0);
        check("reset_dq_out", 32'(sram_dq_out), 32'h0);
        check("reset_ready", 32'(ready), 32'h1);
        @(posedge clk);
        #1;

        // Read 1032: halfwords 4 then 5, ready low for cycles 0..4
        issue(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 1'b0, 5, "rd1032");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("rd1032_ready_c%0d", k), 32'(ready), 32'h0);
            if (k > 0) check($sformatf("rd1032_addr_c%0d", k), 32'(sram_addr),
                             (k < 3) ? 32'd4 : 32'd5);
        end
        wait_done("rd1032");
        idle_cycle();

        // Write 1024
        wlog.delete();
        issue(1'b0, 1'b1, 32'd1024, 32'h12345678, 32'hDEADBEEF, 1'b0, 5, "wr1024");
        wait_done("wr1024");
        idle_cycle();
        exp_a = '{18'd0, 18'd0, 18'd1, 18'd1};
        exp_d = '{16'h5678, 16'h5678, 16'h1234, 16'h1234};
        check("wr1024_strobe_cycles", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wlog.size()) begin
                check($sformatf("wr1024_addr%0d", i), 32'(wlog[i].a), 32'(exp_a[i]));
                check($sformatf("wr1024_data%0d", i), 32'(wlog[i].d), 32'(exp_d[i]));
            end
        end
        check("wr1024_mem0", 32'(mem[0]), 32'h5678);
        check("wr1024_mem1", 32'(mem[1]), 32'h1234);

        // Simultaneous read+write: write wins, rdata untouched
        wlog.delete();
        issue(1'b1, 1'b1, 32'd1028, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0, 5, "rdwr1028");
        @(negedge clk);
        @(negedge clk);
        check("rdwr1028_we_n_c1", 32'(sram_we_n), 32'h0);
        check("rdwr1028_oe_c1", 32'(sram_dq_oe), 32'h1);
        wait_done("rdwr1028");
        idle_cycle();
        check("rdwr1028_strobe_cycles", 32'(wlog.size()), 32'd4);
        check("rdwr1028_mem2", 32'(mem[2]), 32'hCCDD);
        check("rdwr1028_mem3", 32'(mem[3]), 32'hAABB);

        // Back-to-back read then write
        issue(1'b1, 1'b0, 32'd1028, 32'h0, 32'hAABBCCDD, 1'b0, 5, "b2b_rd1028");
        wait_done("b2b_rd1028");
        issue(1'b0, 1'b1, 32'd1036, 32'h0BADF00D, 32'hAABBCCDD, 1'b0, 5, "b2b_wr1036");
        wait_done("b2b_wr1036");
        idle_cycle();
        check("b2b_done_spacing", 32'(done_cyc[$] - done_cyc[$-1]), 32'd6);
        issue(1'b1, 1'b0, 32'd1036, 32'h0, 32'h0BADF00D, 1'b0, 5, "rd1036");
        wait_done("rd1036");
        idle_cycle();

        // Reset during WR_HI
        issue(1'b0, 1'b1, 32'd1040, 32'h55556666, 32'h0BADF00D, 1'b0, 5, "wr1040_rst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_mid_we_n", 32'(sram_we_n), 32'h1);
        check("rst_mid_oe", 32'(sram_dq_oe), 32'h0);
        check("rst_mid_rdata", rdata, 32'h0);
        sb.delete();
        rst = 1'b0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(posedge clk);
        #1;
        issue(1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678, 1'b0, 5, "rd1024_after_rst");
        wait_done("rd1024_after_rst");
        idle_cycle();

`ifdef SRAM_ALIGN_CHECK_EN
        wlog.delete();
        issue(1'b1, 1'b0, 32'd1026, 32'h0, 32'h12345678, 1'b1, 1, "rd1026_misaligned");
        wait_done("rd1026_misaligned");
        idle_cycle();
        issue(1'b0, 1'b1, 32'd1020, 32'hFFFFFFFF, 32'h12345678, 1'b1, 1, "wr1020_below_base");
        wait_done("wr1020_below_base");
        idle_cycle();
        check("illegal_no_strobe", 32'(wlog.size()), 32'd0);
        issue(1'b1, 1'b0, 32'd1032, 32'h0, 32'hDEADBEEF, 1'b0, 5, "rd1032_clears_err");
        wait_done("rd1032_clears_err");
        idle_cycle();
`else
        issue(1'b1, 1'b0, 32'd1030, 32'h0, 32'hAABBCCDD, 1'b0, 5, "rd1030_low_bits_ignored");
        wait_done("rd1030_low_bits_ignored");
        idle_cycle();
`endif

        check("final_pending_expectations", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage SRAM controller sitting directly downstream of the execute-stage ALU. It takes the ALU result as a byte address for LDR/STR and moves one 32-bit word over a 16-bit external SRAM bus as two halfword accesses, with a programmable number of wait cycles per access. While an access is in flight, `ready` is held low so the pipeline freezes. When the access completes, `ready` rises for exactly one cycle.

## Interface
- `BASE_ADDR`, default 1024: byte address of data-memory word 0; subtracted from `address`.
- `WAIT_CYCLES`, default 1: extra cycles each halfword access is held; each phase lasts WAIT_CYCLES+1 cycles; legal range 0..15.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rd_en` in 1: load request (LDR in MEM stage); held stable by the pipeline while `ready`=0.
- `wr_en` in 1: store request (STR); held stable while `ready`=0.
- `address` in 32: ALU result (byte address).
- `wdata` in 32: store data.
- `rdata` out 32: registered load data {high halfword, low halfword}.
- `ready` out 1: 0 freezes the pipeline; 1 means no request or access complete.
- `err` out 1: registered illegal-address flag (see Configuration).
- `sram_addr` out 18: halfword address to SRAM.
- `sram_dq_out` out 16: write data to SRAM.
- `sram_dq_in` in 16: read data from SRAM.
- `sram_dq_oe` out 1: drive enable for the bidirectional pad (top level builds the tristate).
- `sram_we_n` out 1: active-low SRAM write enable.

## Operation
- Address: `off = address - BASE_ADDR` (32-bit, wraps); `word = off[18:2]`; `sram_addr = {word, half}`, where half=0 for the low halfword and 1 for the high halfword; `off[1:0]` is ignored unless the check is enabled.
- FSM states: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
- IDLE → WR_LO if `wr_en`; else → RD_LO if `rd_en`; else stay. If both are asserted, the write wins.
- RD_LO → RD_HI → DONE, and WR_LO → WR_HI → DONE; each transition occurs when the wait counter reaches WAIT_CYCLES.
- The counter clears on every state change.
- DONE → IDLE unconditionally.
- RD_x: `sram_dq_oe`=0, `sram_we_n`=1. On the last cycle of RD_LO, latch `sram_dq_in` into `rdata[15:0]`. On the last cycle of RD_HI, latch it into `rdata[31:16]`.
- WR_x: `sram_dq_oe`=1 and `sram_we_n`=0 for the whole phase. `sram_dq_out` = `wdata[15:0]` in WR_LO and `wdata[31:16]` in WR_HI.
- `ready` (combinational) = !(`rd_en` | `wr_en`) | (state==DONE).
- `rdata` holds its value until the next read completes; writes do not alter it.
- Requests are sampled only in IDLE. If a request is dropped mid-access, the FSM still completes the access.

## Timing
- Reset values:
  - state=IDLE, counter=0, `rdata`=0, `err`=0.
  - `sram_we_n`=1, `sram_dq_oe`=0, `sram_addr`=0, `sram_dq_out`=0.
  - `ready`=1 when no request is present.
- Latency: a request first seen in IDLE at cycle 0 yields DONE (`ready`=1) at cycle 2·(WAIT_CYCLES+1)+1. With the default WAIT_CYCLES=1, that is cycle 5.
- `rdata` is valid in DONE, in the same cycle `ready` rises.
- A back-to-back request takes the cycle after DONE as its IDLE sample cycle. There is no zero-cycle IDLE bypass.
- `rst` asserted in any state returns to IDLE on the next edge and deasserts `sram_we_n` and `sram_dq_oe` immediately. A partial write may corrupt the target word; this is accepted.

## Configuration
- `SRAM_ALIGN_CHECK_EN` defined:
  - In IDLE, a request with `address[1:0]`≠0 or `address`<BASE_ADDR goes straight to DONE with no SRAM activity.
  - `err`=1 is registered in that DONE cycle, and `rdata` is unchanged.
  - `err` clears on the next accepted legal request or on reset.
- `SRAM_ALIGN_CHECK_EN` undefined:
  - No check is performed, and `off[1:0]` is ignored.
  - `err` is tied to 0.

## Structure
- Shared package `sram_ctrl_pkg`: state enum `sram_state_t`, `SRAM_ADDR_W`=18, `SRAM_DATA_W`=16, default `BASE_ADDR`.
- Sub-module `sram_wait_counter`: 4-bit counter with `clr` input and `done` output (count==WAIT_CYCLES), instantiated once.

## Test plan
- Read, WAIT_CYCLES=1:
  - Stimulus: `rd_en`=1, `address`=1032; SRAM model returns 16'hBEEF at halfword address 4 and 16'hDEAD at halfword address 5.
  - Required: `sram_addr` is 4 then 5; `ready`=0 for cycles 0–4 and 1 at cycle 5 with `rdata`=32'hDEADBEEF.
- Write:
  - Stimulus: `wr_en`=1, `address`=1024, `wdata`=32'h12345678.
  - Required: `sram_dq_out` is 16'h5678 at address 0 then 16'h1234 at address 1; `sram_we_n`=0 for 2 cycles each; `rdata` unchanged.
- Simultaneous requests:
  - Stimulus: `rd_en`=`wr_en`=1.
  - Required: the FSM enters WR_LO, and no read latch occurs.
- Reset mid-write:
  - Stimulus: `rst`=1 during WR_HI.
  - Required: next cycle state=IDLE, `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0.
- Back-to-back:
  - Stimulus: a read to 1028 followed by a write to 1036, with requests held per the handshake.
  - Required: two DONE pulses exactly 6 cycles apart.
- Misaligned, `SRAM_ALIGN_CHECK_EN` defined:
  - Stimulus: `address`=1026.
  - Required: `ready`=1 at cycle 1 with `err`=1 and no `sram_we_n` pulse.
